// File: rtl/regfile_pkg.sv
// Shared constants and typedefs for the parametrised register file.
// RF_DATA_W / RF_DEPTH are the default geometry; rf_addr_t and rf_word_t
// give datapath clients matching address and data types.
package regfile_pkg;

    localparam int unsigned RF_DATA_W = 16;
    localparam int unsigned RF_DEPTH  = 32;
    localparam int unsigned RF_ADDR_W = $clog2(RF_DEPTH);

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_word_t;

endpackage : regfile_pkg

// File: rtl/regfile_rd_port.sv
// One registered read port of regfile_param.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           bulk clear happening this cycle
//   re_i            read enable; loads rdata_o and sets rvalid_o
//   raddr_i         read address
//   wr_en_i         legal write happening this cycle (already range/zero checked)
//   waddr_i/wdata_i write address/data, used for write-first bypass
//   arr_word_i      current array contents at raddr_i (0 when out of range)
//   rdata_o         registered read data, holds when re_i=0
//   rvalid_o        registered read-valid strobe
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter bit          ZERO_REG = 1'b0,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] arr_word_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              rd_zero;
    logic              bypass;
    logic [DATA_W-1:0] rd_value;

    // Masking wins over bypass: an out-of-range or hard-zero address reads 0
    // even if a (necessarily ignored) write targets it.
    assign rd_zero = ({1'b0, raddr_i} >= DEPTH_C) ||
                     (ZERO_REG && (raddr_i == '0));
    assign bypass  = wr_en_i && (waddr_i == raddr_i);

    always_comb begin
        rd_value = arr_word_i;
        if (rd_zero) begin
            rd_value = '0;
        end else if (bypass) begin
            rd_value = wdata_i;
        end else if (clr_i) begin
            rd_value = '0;
        end
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = re_i;
        if (re_i) begin
            rdata_d = rd_value;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule : regfile_rd_port

// File: rtl/regfile_param.sv
// Parametrised clocked register file: DEPTH words of DATA_W bits, one
// synchronous write port, NUM_RD registered read ports with write-first
// bypass, optional hard-wired zero register and single-cycle bulk clear.
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   clr         clear every register (a same-cycle write still lands)
//   we/waddr/wdata  write port; out-of-range or zero-register writes ignored
//   re          per-port read enable
//   raddr       packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata       packed registered read data, port i at [i*DATA_W +: DATA_W]
//   rvalid      per-port read-valid strobe
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b0,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rvalid
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_legal;

    assign wr_legal = we && ({1'b0, waddr} < DEPTH_C) &&
                      !(ZERO_REG && (waddr == '0));

    // Clear first, then the write, so a same-cycle write survives the clear.
    // Indexing is done by comparison so non-power-of-two depths never index
    // past the array.
    always_comb begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
            mem_d[j] = clr ? '0 : mem_q[j];
            if (wr_legal && (waddr == ADDR_W'(j))) begin
                mem_d[j] = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem_q[j] <= mem_d[j];
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] arr_word;

        assign ra = raddr[g*ADDR_W +: ADDR_W];

        always_comb begin
            arr_word = '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (ra == ADDR_W'(j)) begin
                    arr_word = mem_q[j];
                end
            end
        end

        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ZERO_REG(ZERO_REG),
            .ADDR_W  (ADDR_W)
        ) u_rd_port (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .clr_i     (clr),
            .re_i      (re[g]),
            .raddr_i   (ra),
            .wr_en_i   (wr_legal),
            .waddr_i   (waddr),
            .wdata_i   (wdata),
            .arr_word_i(arr_word),
            .rdata_o   (rdata[g*DATA_W +: DATA_W]),
            .rvalid_o  (rvalid[g])
        );
    end

endmodule : regfile_param

// File: doc/regfile_param.md
# regfile_param

Parametrised, clocked multi-port register file that supersedes the fixed 16-bit × 32-entry combinational register file. It holds `DEPTH` words of `DATA_W` bits and provides one synchronous write port, `NUM_RD` registered read ports with write-to-read bypass, an optional hard-wired zero register and a single-cycle bulk clear. It sits between the datapath's operand-fetch stage and the adder/ALU, replacing the testbench-driven feedback of the whole register array.

## Interface
- `DATA_W`, 16, word width in bits.
- `DEPTH`, 32, number of registers; any value ≥ 2, need not be a power of two.
- `NUM_RD`, 2, number of read ports, 1..4.
- `ZERO_REG`, 0, when 1 register 0 always reads 0 and ignores writes.
- `ADDR_W`, `$clog2(DEPTH)`, derived; do not override.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of all registers.
- `we`  in  1  write enable.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  DATA_W  write data.
- `re`  in  NUM_RD  per-port read enable.
- `raddr`  in  NUM_RD×ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- `rdata`  out  NUM_RD×DATA_W  packed registered read data.
- `rvalid`  out  NUM_RD  per-port read-data-valid strobe.

## Operation
- Reset (`rst_n`=0, asynchronous): every register, every `rdata` lane and every `rvalid` bit go to 0 immediately and stay 0 while reset is held.
- Write: at a rising edge with `we`=1, `mem[waddr]` takes `wdata`. The write is ignored when `waddr` ≥ DEPTH, or when `waddr`=0 and ZERO_REG=1.
- Clear: at a rising edge with `clr`=1, every register becomes 0. If `we` is also 1 in that cycle, the write is applied after the clear, so `mem[waddr]`=wdata and all other registers are 0.
- Read, per port i: at a rising edge with `re[i]`=1, `rdata[i]` is loaded and `rvalid[i]` is set to 1. With `re[i]`=0, `rvalid[i]` goes to 0 and `rdata[i]` holds its previous value.
- Read value, highest priority first:
  1. 0 when `raddr[i]` ≥ DEPTH, or when `raddr[i]`=0 and ZERO_REG=1.
  2. `wdata` when `we`=1 and `waddr`=`raddr[i]` and the write is legal (write-first bypass).
  3. 0 when `clr`=1.
  4. Otherwise `mem[raddr[i]]`.
- Multiple ports may read the same address in the same cycle; each port sees the identical value.
- There is no arithmetic; all data is passed through unmodified at DATA_W bits.

## Timing
- Write latency is 1 cycle: data written at edge N is visible to a plain array read at edge N+1, and to a bypassed read at edge N.
- Read latency is 1 cycle: address presented before edge N produces `rdata`/`rvalid` valid after edge N.
- Back-to-back reads on every port are supported every cycle; no stalls and no backpressure.
- Reset deasserted mid-operation: the first edge after release behaves as a normal cycle on an all-zero array.

## Structure
- Package `regfile_pkg`: default constants `RF_DATA_W`=16 and `RF_DEPTH`=32, plus the `rf_addr_t` and `rf_word_t` typedefs used by datapath clients.
- Sub-module `regfile_rd_port`: one read port (bypass mux, zero/out-of-range masking, output register), instantiated `NUM_RD` times in a generate loop.
- The storage array, write logic and clear logic live in the top module.

## Test plan
- Reset then read: hold `rst_n` low, release, read addr 5 on both ports → `rdata` = 0x0000, `rvalid` = 1 one cycle later.
- Write then read: write 0x1232 to addr 0 and 0x1263 to addr 1, then read port 0 = addr 0 and port 1 = addr 1 → next cycle 0x1232 and 0x1263; feeding the adder gives 0x2495. Write 0x2495 to addr 2 and read it back → 0x2495.
- Bypass: in the same cycle write 0xBEEF to addr 7 and read addr 7 on port 0 → 0xBEEF after that edge; port 1 reading addr 6 gets its old value.
- Clear plus write: with `clr`=1 and a write of 0x00AA to addr 3 in the same cycle → next cycle reads give addr 3 = 0x00AA and addr 0, 1, 2 = 0x0000.
- ZERO_REG=1 and DEPTH=24: write 0xFFFF to addr 0 and to addr 30, then read both → 0x0000, with `rvalid` = 1.
- Asynchronous reset mid-stream: assert `rst_n`=0 between edges while `rvalid`=1 → `rdata` and `rvalid` drop to 0 immediately, before the next edge; after release, prior contents read back as 0.
